// File: rtl/uart_host_scheduler.sv
// APB master that configures a 16550-style UART, then forwards requester bytes
// to THR using round-robin arbitration and LSR-polled TX credits.
module uart_host_scheduler #(
  parameter int          NUM_REQ        = 2,
  parameter int          APB_ADDR_WIDTH = 12,
  parameter logic [15:0] DIVISOR        = 16'd27,
  parameter logic [7:0]  LCR_CFG        = 8'h03,
  parameter logic [7:0]  FCR_CFG        = 8'h06,
  parameter int          TX_CREDITS     = 16
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [8*NUM_REQ-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      reinit_i,
  output logic                      init_done_o,
  output logic                      err_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CRD_W = $clog2(TX_CREDITS) + 1;
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(TX_CREDITS);

  typedef enum logic [2:0] {
    INIT_SETUP, INIT_ACCESS, IDLE, POLL_SETUP, POLL_ACCESS, WR_SETUP, WR_ACCESS
  } state_t;

  state_t             state_q, state_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [2:0]         paddr_q, paddr_d;
  logic [7:0]         pwdata_q, pwdata_d;
  logic [2:0]         step_q, step_d;
  logic [CRD_W-1:0]   credits_q, credits_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         byte_q, byte_d;
  logic               init_done_q, init_done_d;
  logic               err_q, err_d;

  logic               acc_done;
  logic               grant_fire;
  logic               gnt_valid;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   gnt_offs;
  logic [PTR_W:0]     gnt_sum;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0] rot_valid;
  logic [10:0]        init_cur;
  logic [10:0]        init_next;
  logic               prdata_unused;

  // Init table entry: {register index, write data}
  function automatic logic [10:0] init_word(input logic [2:0] s);
    case (s)
      3'd0:    init_word = {3'd3, 8'h80};
      3'd1:    init_word = {3'd0, DIVISOR[7:0]};
      3'd2:    init_word = {3'd1, DIVISOR[15:8]};
      3'd3:    init_word = {3'd3, LCR_CFG & 8'h7F};
      3'd4:    init_word = {3'd2, FCR_CFG};
      default: init_word = {3'd1, 8'h00};
    endcase
  endfunction

  assign init_cur  = init_word(step_q);
  assign init_next = init_word(step_q + 3'd1);
  assign acc_done  = penable_q & PREADY;

  // Rotate the request vector so bit 0 is the requester at ptr_q.
  assign dbl_valid = {req_valid_i, req_valid_i};
  assign rot_valid = NUM_REQ'(dbl_valid >> ptr_q);

  always_comb begin
    gnt_offs = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) gnt_offs = PTR_W'(k);
    end
    gnt_valid = |rot_valid;
    gnt_sum   = {1'b0, ptr_q} + {1'b0, gnt_offs};
    if (gnt_sum >= (PTR_W+1)'(NUM_REQ)) gnt_idx = PTR_W'(gnt_sum - (PTR_W+1)'(NUM_REQ));
    else                                gnt_idx = PTR_W'(gnt_sum);
  end

  assign grant_fire = (state_q == IDLE) && init_done_q && !reinit_i && gnt_valid;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = grant_fire && (gnt_idx == PTR_W'(gi));
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    step_d      = step_q;
    credits_d   = credits_q;
    ptr_d       = ptr_q;
    byte_d      = byte_q;
    init_done_d = init_done_q;
    err_d       = err_q | (acc_done & PSLVERR);

    case (state_q)
      INIT_SETUP: begin
        psel_d              = 1'b1;
        pwrite_d            = 1'b1;
        {paddr_d, pwdata_d} = init_cur;
        state_d             = INIT_ACCESS;
      end
      INIT_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (acc_done) begin
          if (step_q == 3'd5) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Chain straight into the next SETUP phase, no idle gap.
            penable_d           = 1'b0;
            step_d              = step_q + 3'd1;
            {paddr_d, pwdata_d} = init_next;
          end
        end
      end
      IDLE: begin
        if (reinit_i) begin
          init_done_d = 1'b0;
          credits_d   = '0;
          step_d      = '0;
          state_d     = INIT_SETUP;
        end else if (grant_fire) begin
          byte_d  = req_data_i[{gnt_idx, 3'b000} +: 8];
          ptr_d   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = (credits_q == '0) ? POLL_SETUP : WR_SETUP;
        end
      end
      POLL_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b0;
        paddr_d  = 3'd5;
        pwdata_d = 8'h00;
        state_d  = POLL_ACCESS;
      end
      POLL_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (acc_done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (PRDATA[5]) begin
            credits_d = CRD_FULL;
            state_d   = WR_SETUP;
          end else begin
            state_d   = POLL_SETUP;
          end
        end
      end
      WR_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = 3'd0;
        pwdata_d = byte_q;
        state_d  = WR_ACCESS;
      end
      WR_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (acc_done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (credits_q != '0) credits_d = credits_q - 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = INIT_SETUP;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= INIT_SETUP;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      step_q      <= '0;
      credits_q   <= '0;
      ptr_q       <= '0;
      byte_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      step_q      <= step_d;
      credits_q   <= credits_d;
      ptr_q       <= ptr_d;
      byte_q      <= byte_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign PSEL          = psel_q;
  assign PENABLE       = penable_q;
  assign PWRITE        = pwrite_q;
  assign PADDR         = APB_ADDR_WIDTH'(paddr_q);
  assign PWDATA        = {24'h000000, pwdata_q};
  assign init_done_o   = init_done_q;
  assign err_o         = err_q;
  // Only LSR[5] (THR empty) matters to this block.
  assign prdata_unused = ^{PRDATA[31:6], PRDATA[4:0]};

endmodule

// File: tb/tb_uart_host_scheduler.sv
// Directed bench: APB slave model with stall/error injection, transfer log
// compared against hand-computed sequences.
module tb_uart_host_scheduler;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b1;
  logic        PSLVERR = 1'b0;
  logic [1:0]  req_valid_i = 2'b00;
  logic [15:0] req_data_i = 16'h0;
  logic [1:0]  req_ready_o;
  logic        reinit_i = 1'b0;
  logic        init_done_o, err_o;

  uart_host_scheduler dut (
    .CLK(CLK), .RSTN(RSTN), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .reinit_i(reinit_i), .init_done_o(init_done_o),
    .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        wr;
    int          acc;
    int          gap;
  } xfer_t;

  xfer_t      log_q[$];
  logic [7:0] lsr_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Slave-model controls and bookkeeping
  logic        stall_armed = 1'b0, stall_wr = 1'b0;
  logic [11:0] stall_addr = '0;
  int          stall_n = 0, stall_cnt = 0;
  logic        err_armed = 1'b0, err_wr = 1'b0;
  logic [11:0] err_addr = '0;
  logic [11:0] s_addr = '0;
  logic [31:0] s_data = '0;
  logic        s_wr = 1'b0, rdy_prev = 1'b0;
  int          acc_cnt = 0, idle_cnt = 0, s_gap = 0, hold_bad = 0, rdy_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // APB slave: decides PREADY/PSLVERR/PRDATA for the next edge and logs completions.
  always @(negedge CLK) begin
    xfer_t x;
    if (!RSTN) begin
      PREADY = 1'b1; PSLVERR = 1'b0; idle_cnt = 0; rdy_prev = 1'b0;
    end else begin
      if (PSEL && !PENABLE) begin
        s_addr = PADDR; s_data = PWDATA; s_wr = PWRITE;
        acc_cnt = 0; s_gap = idle_cnt; idle_cnt = 0;
      end else if (!PSEL) begin
        idle_cnt++;
      end
      PREADY = 1'b1; PSLVERR = 1'b0;
      if (PSEL && PENABLE) begin
        acc_cnt++;
        if (PADDR !== s_addr || PWDATA !== s_data || PWRITE !== s_wr) hold_bad++;
        if (stall_armed && PADDR == stall_addr && PWRITE == stall_wr && stall_cnt < stall_n) begin
          PREADY = 1'b0;
          stall_cnt++;
        end else begin
          if (stall_armed && PADDR == stall_addr && PWRITE == stall_wr) stall_armed = 1'b0;
          if (err_armed && PADDR == err_addr && PWRITE == err_wr) begin
            PSLVERR = 1'b1;
            err_armed = 1'b0;
          end
          if (!PWRITE) begin
            if (lsr_q.size() > 0) PRDATA = {24'h0, lsr_q.pop_front()};
            else                  PRDATA = 32'h60;
          end
          x.addr = PADDR; x.wr = PWRITE; x.acc = acc_cnt; x.gap = s_gap;
          x.data = PWRITE ? PWDATA : PRDATA;
          log_q.push_back(x);
          $display("xfer %0d: %s idx=%0d data=%02h acc=%0d gap=%0d", log_q.size() - 1,
                   PWRITE ? "WR" : "RD", PADDR, x.data[7:0], acc_cnt, s_gap);
        end
      end
      if (|req_ready_o) begin
        if ($countones(req_ready_o) != 1 || rdy_prev || !init_done_o) rdy_bad++;
      end
      rdy_prev = |req_ready_o;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    req_valid_i = 2'b00;
    reinit_i = 1'b0;
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_init_done", init_done_o, 0);
    check("rst_err", err_o, 0);
    repeat (2) @(negedge CLK);
    log_q.delete(); lsr_q.delete();
    stall_armed = 1'b0; stall_cnt = 0; err_armed = 1'b0;
    hold_bad = 0; rdy_bad = 0;
    RSTN = 1'b1;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_log_count"}, 32'(log_q.size() >= n), 1);
  endtask

  task automatic wait_init(input string tag);
    int k = 0;
    while (!init_done_o && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_init_done"}, init_done_o, 1);
  endtask

  task automatic check_init_log(input string tag, input int base);
    logic [11:0] ea[6];
    logic [7:0]  ed[6];
    ea = '{12'd3, 12'd0, 12'd1, 12'd3, 12'd2, 12'd1};
    ed = '{8'h80, 8'h1B, 8'h00, 8'h03, 8'h06, 8'h00};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_init%0d_addr", tag, i), log_q[base+i].addr, ea[i]);
      check($sformatf("%s_init%0d_data", tag, i), log_q[base+i].data, ed[i]);
      check($sformatf("%s_init%0d_wr", tag, i), log_q[base+i].wr, 1);
    end
  endtask

  initial begin
    #2 RSTN = 1'b0;

    // Init sequence timing with PREADY always high
    do_reset();
    @(negedge CLK);
    check("t1_first_setup_psel", PSEL, 1);
    check("t1_first_setup_penable", PENABLE, 0);
    check("t1_first_setup_paddr", PADDR, 3);
    check("t1_first_setup_pwdata", PWDATA, 32'h80);
    repeat (11) @(negedge CLK);
    check("t1_init_done_c12", init_done_o, 0);
    @(negedge CLK);
    check("t1_init_done_c13", init_done_o, 1);
    check("t1_psel_after_init", PSEL, 0);
    check("t1_log_size", log_q.size(), 6);
    check_init_log("t1", 0);
    for (int i = 1; i < 6; i++) check($sformatf("t1_gap%0d", i), log_q[i].gap, 0);
    check("t1_hold", hold_bad, 0);

    // Three wait states on the DLL write
    do_reset();
    stall_armed = 1'b1; stall_addr = 12'd0; stall_wr = 1'b1; stall_n = 3; stall_cnt = 0;
    wait_log(6, "t2");
    wait_init("t2");
    check_init_log("t2", 0);
    check("t2_dll_access_cycles", log_q[1].acc, 4);
    check("t2_dlm_gap", log_q[2].gap, 0);
    check("t2_hold", hold_bad, 0);

    // Two requesters continuously valid: alternate A0/B0
    do_reset();
    req_valid_i = 2'b11; req_data_i = 16'hB0A0;
    wait_log(12, "t3");
    check("t3_poll_wr", log_q[6].wr, 0);
    check("t3_poll_addr", log_q[6].addr, 5);
    for (int i = 7; i < 12; i++) begin
      check($sformatf("t3_thr%0d_addr", i), log_q[i].addr, 0);
      check($sformatf("t3_thr%0d_data", i), log_q[i].data, (i % 2 == 1) ? 32'hA0 : 32'hB0);
    end
    check("t3_ready_pulse", rdy_bad, 0);
    check("t3_hold", hold_bad, 0);

    // LSR busy twice, then 16 credits, then a poll before the 17th byte
    do_reset();
    lsr_q.push_back(8'h00); lsr_q.push_back(8'h00);
    lsr_q.push_back(8'h60); lsr_q.push_back(8'h60);
    req_valid_i = 2'b01; req_data_i = 16'h005A;
    wait_log(27, "t4");
    for (int i = 6; i < 27; i++) begin
      logic ewr;
      ewr = !(i <= 8 || i == 25);
      check($sformatf("t4_x%0d_wr", i), log_q[i].wr, ewr);
      check($sformatf("t4_x%0d_addr", i), log_q[i].addr, ewr ? 12'd0 : 12'd5);
      if (ewr) check($sformatf("t4_x%0d_data", i), log_q[i].data, 32'h5A);
    end
    check("t4_ready_pulse", rdy_bad, 0);

    // PSLVERR on the FCR write
    do_reset();
    err_armed = 1'b1; err_addr = 12'd2; err_wr = 1'b1;
    repeat (3) @(negedge CLK);
    check("t5_err_before", err_o, 0);
    wait_log(6, "t5");
    wait_init("t5");
    check_init_log("t5", 0);
    check("t5_err_set", err_o, 1);
    repeat (5) @(negedge CLK);
    check("t5_err_sticky", err_o, 1);

    // Reset during a poll ACCESS, then full restart
    do_reset();
    stall_armed = 1'b1; stall_addr = 12'd5; stall_wr = 1'b0; stall_n = 50; stall_cnt = 0;
    req_valid_i = 2'b01; req_data_i = 16'h0077;
    begin
      int k = 0;
      while (!(PSEL && PENABLE && !PWRITE) && k < 300) begin
        @(negedge CLK);
        k++;
      end
    end
    check("t6_poll_access_seen", {PSEL, PENABLE, PWRITE}, 3'b110);
    do_reset();
    req_valid_i = 2'b01; req_data_i = 16'h0077;
    wait_log(8, "t6");
    check_init_log("t6", 0);
    check("t6_poll_wr", log_q[6].wr, 0);
    check("t6_poll_addr", log_q[6].addr, 5);
    check("t6_byte_addr", log_q[7].addr, 0);
    check("t6_byte_data", log_q[7].data, 32'h77);

    // Reinit clears credits and blocks the concurrent grant
    do_reset();
    req_valid_i = 2'b01; req_data_i = 16'h0033;
    begin
      int k = 0;
      while (!req_ready_o[0] && k < 200) begin
        @(negedge CLK);
        k++;
      end
    end
    @(posedge CLK);
    #1 req_valid_i = 2'b00;
    wait_log(8, "t7");
    repeat (3) @(negedge CLK);
    req_valid_i = 2'b01; req_data_i = 16'h0044; reinit_i = 1'b1;
    #1;
    check("t7_reinit_no_ready", req_ready_o, 0);
    @(negedge CLK);
    reinit_i = 1'b0;
    check("t7_init_done_drop", init_done_o, 0);
    wait_log(16, "t7b");
    check_init_log("t7", 8);
    check("t7_poll_wr", log_q[14].wr, 0);
    check("t7_poll_addr", log_q[14].addr, 5);
    check("t7_byte_data", log_q[15].data, 32'h44);
    check("t7_ready_pulse", rdy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_host_scheduler.md
UART_HOST_SCHEDULER -- requirements
Module: uart_host_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning the number of TX byte requesters (range 1..8).
REQ-002 The block SHALL have parameter APB_ADDR_WIDTH, default 12, meaning the APB master address width.
REQ-003 The block SHALL have parameter DIVISOR, default 16'd27, meaning the baud divisor programmed into DLM:DLL.
REQ-004 The block SHALL have parameter LCR_CFG, default 8'h03, meaning the line-control value (8N1, DLAB=0).
REQ-005 The block SHALL have parameter FCR_CFG, default 8'h06, meaning the FIFO-control value written at init (clear both FIFOs).
REQ-006 The block SHALL have parameter TX_CREDITS, default 16, meaning the bytes written after each LSR[5]=1 poll (equals UART TX FIFO depth).
REQ-007 The block SHALL have port CLK, input, 1 bit, the clock.
REQ-008 The block SHALL have port RSTN, input, 1 bit, the reset (asynchronous, active-low).
REQ-009 The block SHALL have port PADDR, output, APB_ADDR_WIDTH bits, the APB address, equal to the zero-extended 3-bit UART register index.
REQ-010 The block SHALL have ports PWDATA (output, 32), PWRITE (output, 1), PSEL (output, 1) and PENABLE (output, 1), the APB master controls.
REQ-011 The block SHALL have ports PRDATA (input, 32), PREADY (input, 1) and PSLVERR (input, 1), the APB slave responses.
REQ-012 The block SHALL have ports req_valid_i (input, NUM_REQ), req_data_i (input, 8*NUM_REQ, byte i at [8i+7:8i]) and req_ready_o (output, NUM_REQ), the requester byte handshakes.
REQ-013 The block SHALL have port reinit_i, input, 1 bit, a request to rerun the init sequence.
REQ-014 The block SHALL have port init_done_o, output, 1 bit, high when the UART is configured.
REQ-015 The block SHALL have port err_o, output, 1 bit, a sticky flag for any PSLVERR seen.

Function
REQ-016 Every APB access SHALL take a SETUP cycle (PSEL=1, PENABLE=0), then ACCESS cycles (PSEL=1, PENABLE=1) held until PREADY=1; PADDR, PWDATA and PWRITE SHALL be stable across both.
REQ-017 Between accesses PSEL and PENABLE SHALL be 0; back-to-back accesses are allowed, so a SETUP may directly follow a completing ACCESS.
REQ-018 PSLVERR=1 at completion SHALL set err_o; the access SHALL NOT be retried; the sequence SHALL continue; err_o SHALL clear only on reset.
REQ-019 The init sequence SHALL run these writes in order: idx3=8'h80; idx0=DIVISOR[7:0]; idx1=DIVISOR[15:8]; idx3=LCR_CFG&8'h7F; idx2=FCR_CFG; idx1=8'h00. PWDATA[31:8] SHALL be 0.
REQ-020 init_done_o SHALL rise in the cycle after the sixth write completes; with PREADY tied high that is cycle 13 after reset release.
REQ-021 The FSM states SHALL be INIT_SETUP, INIT_ACCESS, IDLE, POLL_SETUP, POLL_ACCESS, WR_SETUP and WR_ACCESS.
REQ-022 In IDLE with any req_valid_i set, the block SHALL grant exactly one requester round-robin, starting at pointer ptr and searching upward with wrap.
REQ-023 req_ready_o[g] SHALL be high only in that IDLE cycle; the byte SHALL be captured at that edge; ptr SHALL become (g+1) mod NUM_REQ; req_ready_o SHALL be all-zero in every other state.
REQ-024 After a grant, if credits==0 the FSM SHALL go to POLL_SETUP, else to WR_SETUP.
REQ-025 The poll SHALL read idx5 (LSR); if PRDATA[5]=1, credits SHALL be set to TX_CREDITS and the FSM SHALL go to WR_SETUP; else it SHALL go back to POLL_SETUP.
REQ-026 A write SHALL target idx0 (THR) with the captured byte; on completion credits SHALL decrement by 1 (never below 0) and the FSM SHALL return to IDLE.
REQ-027 The credits counter SHALL be $clog2(TX_CREDITS)+1 bits wide.
REQ-028 reinit_i SHALL be sampled only in IDLE and SHALL take priority over a grant.
REQ-029 On reinit: init_done_o SHALL drop next cycle; credits SHALL clear to 0; the init sequence SHALL restart; no req_ready_o SHALL be issued that cycle.
REQ-030 While init_done_o=0, no grants SHALL occur.
REQ-031 With NUM_REQ=1 the block SHALL always grant requester 0 and ptr SHALL stay 0.

Reset
REQ-032 Reset SHALL immediately force PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_ready_o=0, init_done_o=0 and err_o=0.
REQ-033 Reset SHALL also force credits=0, ptr=0, init step=0 and state INIT_SETUP.
REQ-034 A reset mid-access SHALL abandon that access; a captured but unsent byte SHALL be dropped.
REQ-035 The first SETUP cycle SHALL be the first clock edge after RSTN rises.

Verification
REQ-036 Reset release with PREADY=1 -> six writes (addr/data 3/80, 0/1B, 1/00, 3/03, 2/06, 1/00); init_done_o=1 at cycle 13.
REQ-037 PREADY low for 3 ACCESS cycles on the DLL write -> PSEL/PENABLE/PADDR/PWDATA held; next write SETUP directly follows completion.
REQ-038 Both requesters valid continuously, bytes 8'hA0 and 8'hB0 -> THR writes alternate A0, B0, A0, ...; each req_ready_o is a 1-cycle pulse.
REQ-039 LSR returns 8'h00 twice then 8'h60 -> three poll reads, then 16 THR writes with no poll, then a poll before the 17th byte.
REQ-040 PSLVERR=1 on the FCR write -> err_o=1 and stays 1; remaining init write still issued; init_done_o=1.
REQ-041 RSTN low during a poll ACCESS -> PSEL=0 same cycle; after release, init restarts; credits=0 so the first byte is preceded by a poll.
